pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor that replaces the fixed-width ripple-carry adders in the floating-point datapath (mantissa, exponent and remainder arithmetic). The carry chain is split into `STAGES` equal segments, with one register stage per segment, so wide operands close timing at full clock rate. The block accepts one operation per cycle through a valid/ready handshake with backpressure. It also adds subtract mode, carry/borrow-in, and signed-overflow and zero flags.

---
 rtl/pipelined_addsub.sv | 123 ++++++++++++
 tb/tb_pipelined_addsub.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into STAGES
// segments, one register stage each, with a global-stall valid/ready handshake.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 48,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int unsigned SEG   = WIDTH / STAGES;
   localparam int unsigned SEGP1 = SEG + 1;
   localparam int unsigned LAST  = STAGES - 1;

   logic [STAGES-1:0] r_v;
   logic [STAGES-1:0] r_c;
   logic [WIDTH-1:0]  r_a [STAGES];
   logic [WIDTH-1:0]  r_b [STAGES];
   logic [WIDTH-1:0]  r_s [STAGES];
   logic              r_ovf;
   logic              r_zero;

   logic              w_advance;
   logic [STAGES-1:0] w_v_src;
   logic [STAGES-1:0] w_c_src;
   logic [STAGES-1:0] w_c_nxt;
   logic [WIDTH-1:0]  w_a_src [STAGES];
   logic [WIDTH-1:0]  w_b_src [STAGES];
   logic [WIDTH-1:0]  w_s_src [STAGES];
   logic [WIDTH-1:0]  w_s_nxt [STAGES];
   logic [SEGP1-1:0]  w_seg   [STAGES];
   logic              w_ovf;
   logic              w_zero;

   // Global stall: everything moves only when the output slot is free or being drained.
   assign w_advance = !r_v[LAST] || out_ready;
   assign in_ready  = w_advance;

   // Stage k sums segment k from what stage k-1 registered; stage 0 draws from the ports.
   always_comb begin
      w_v_src = '0;
      w_c_src = '0;
      w_c_nxt = '0;
      w_a_src = '{default: '0};
      w_b_src = '{default: '0};
      w_s_src = '{default: '0};
      w_s_nxt = '{default: '0};
      w_seg   = '{default: '0};

      w_v_src[0] = in_valid;
      w_a_src[0] = in1;
      w_b_src[0] = sub ? ~in2 : in2;
      w_c_src[0] = cin ^ sub;
      for (int k = 1; k < STAGES; k++) begin
         w_v_src[k] = r_v[k-1];
         w_a_src[k] = r_a[k-1];
         w_b_src[k] = r_b[k-1];
         w_s_src[k] = r_s[k-1];
         w_c_src[k] = r_c[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         w_seg[k] = SEGP1'(w_a_src[k][k*SEG +: SEG]) + SEGP1'(w_b_src[k][k*SEG +: SEG])
                  + SEGP1'(w_c_src[k]);
         w_s_nxt[k] = w_s_src[k];
         w_s_nxt[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
         w_c_nxt[k] = w_seg[k][SEG];
      end

      // Carry into the MSB is recovered as a^b^s at that bit.
      w_ovf  = w_a_src[LAST][WIDTH-1] ^ w_b_src[LAST][WIDTH-1]
             ^ w_s_nxt[LAST][WIDTH-1] ^ w_c_nxt[LAST];
      w_zero = (w_s_nxt[LAST] == '0);
   end

   // Stage registers; data only loads behind a valid bit so a stalled result stays put.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v    <= '0;
         r_c    <= '0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
      end else if (w_advance) begin
         r_v <= w_v_src;
         for (int k = 0; k < STAGES; k++) begin
            if (w_v_src[k]) begin
               r_a[k] <= w_a_src[k];
               r_b[k] <= w_b_src[k];
               r_s[k] <= w_s_nxt[k];
               r_c[k] <= w_c_nxt[k];
            end
         end
         if (w_v_src[LAST]) begin
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
         end
      end
   end

   assign out_valid = r_v[LAST];
   assign S         = r_s[LAST];
   assign Cout      = r_c[LAST];
   assign Ovf       = r_ovf;
   assign Zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 48-bit/4-stage instance and a 10-bit/1-stage instance,
// directed vectors plus randomized traffic scored against an arithmetic reference.
module tb_pipelined_addsub;

   localparam int unsigned W  = 48;
   localparam int unsigned NW = 10;

   logic          clk;
   logic          rst;
   logic          in_valid, in_ready, sub, cin, out_valid, out_ready, Cout, Ovf, Zero;
   logic [W-1:0]  in1, in2, S;
   logic          n_in_valid, n_in_ready, n_sub, n_cin, n_out_valid, n_out_ready;
   logic          n_Cout, n_Ovf, n_Zero;
   logic [NW-1:0] n_in1, n_in2, n_S;

   pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .sub(sub), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .Cout(Cout), .Ovf(Ovf), .Zero(Zero));

   pipelined_addsub #(.WIDTH(NW), .STAGES(1)) dut_n (
      .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
      .in1(n_in1), .in2(n_in2), .sub(n_sub), .cin(n_cin),
      .out_valid(n_out_valid), .out_ready(n_out_ready),
      .S(n_S), .Cout(n_Cout), .Ovf(n_Ovf), .Zero(n_Zero));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] s;
      bit          cout;
      bit          ovf;
      bit          zero;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      bit           sb;
      bit           ci;
      logic [W-1:0] s;
      bit           cout;
      bit           ovf;
      bit           zero;
      string        name;
   } vec_t;

   int          n_checks;
   int          n_fail;
   int          n_stall;
   exp_t        q[$];
   logic [63:0] fired[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: unsigned result/carry and signed overflow from plain integer arithmetic.
   function automatic exp_t model(input int unsigned w, input logic [63:0] a_in,
                                  input logic [63:0] b_in, input bit sb, input bit ci);
      exp_t        e;
      logic [63:0] mask, a, b, full;
      longint      sa, sbv, r, lim;
      mask = (64'd1 << w) - 64'd1;
      a = a_in & mask;
      b = b_in & mask;
      if (!sb) begin
         full   = a + b + 64'(ci);
         e.cout = full[w];
         e.s    = full & mask;
      end else begin
         e.cout = (a >= b + 64'(ci));
         e.s    = (a - b - 64'(ci)) & mask;
      end
      lim = longint'(64'd1 << (w - 1));
      sa  = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
      sbv = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
      r   = sb ? sa - sbv - longint'(ci) : sa + sbv + longint'(ci);
      e.ovf  = (r >= lim) || (r < -lim);
      e.zero = (e.s == 64'd0);
      return e;
   endfunction

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return '1;
         1:       return '0;
         2:       return 48'h7FFF_FFFF_FFFF;
         3:       return 48'h8000_0000_0000;
         default: return 48'({$urandom(), $urandom()});
      endcase
   endfunction

   // One clock cycle of the wide DUT, entered and left at posedge+1, with scoreboarding.
   task automatic cycle(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sb, input bit ci, input bit ordy, output bit acc);
      in_valid  = iv;
      in1       = a;
      in2       = b;
      sub       = sb;
      cin       = ci;
      out_ready = ordy;
      #1;
      chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || ordy));
      if (!in_ready) n_stall++;
      if (out_valid) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_result: got out_valid=1 S=%0h expected no result", S);
         end else begin
            chk("sb_S", 64'(S), q[0].s);
            chk("sb_Cout", 64'(Cout), 64'(q[0].cout));
            chk("sb_Ovf", 64'(Ovf), 64'(q[0].ovf));
            chk("sb_Zero", 64'(Zero), 64'(q[0].zero));
            if (ordy) begin
               fired.push_back(64'(S));
               void'(q.pop_front());
            end
         end
      end
      acc = iv && in_ready;
      if (acc) q.push_back(model(W, 64'(a), 64'(b), sb, ci));
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input bit sb,
                          input bit ci, output logic [W-1:0] s, output bit co,
                          output bit ov, output bit z, output int lat);
      in_valid  = 1'b1;
      in1       = a;
      in2       = b;
      sub       = sb;
      cin       = ci;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 16) begin
         @(posedge clk);
         #1;
         lat++;
      end
      s  = S;
      co = Cout;
      ov = Ovf;
      z  = Zero;
   endtask

   task automatic run_narrow(input logic [NW-1:0] a, input logic [NW-1:0] b, input bit sb,
                             input bit ci, output logic [NW-1:0] s, output bit co,
                             output bit ov, output bit z, output int lat);
      n_in_valid  = 1'b1;
      n_in1       = a;
      n_in2       = b;
      n_sub       = sb;
      n_cin       = ci;
      n_out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_in_valid = 1'b0;
      lat        = 1;
      while (!n_out_valid && lat < 16) begin
         @(posedge clk);
         #1;
         lat++;
      end
      s  = n_S;
      co = n_Cout;
      ov = n_Ovf;
      z  = n_Zero;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vt[8];
      logic [W-1:0]  s;
      logic [NW-1:0] ns;
      bit            co, ov, z, acc;
      int            lat, seen;
      exp_t          e;

      n_checks = 0;
      n_fail   = 0;
      n_stall  = 0;
      rst = 1'b1;
      in_valid = 1'b0; in1 = '0; in2 = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
      n_in_valid = 1'b0; n_in1 = '0; n_in2 = '0; n_sub = 1'b0; n_cin = 1'b0;
      n_out_ready = 1'b0;

      vt[0] = '{48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 48'h0, 1'b1, 1'b0, 1'b1, "carry_chain"};
      vt[1] = '{48'h5, 48'h7, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0, "sub_borrow"};
      vt[2] = '{48'h7, 48'h5, 1'b1, 1'b0, 48'h2, 1'b1, 1'b0, 1'b0, "sub_plain"};
      vt[3] = '{48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1, 1'b0,
                "add_ovf"};
      vt[4] = '{48'h8000_0000_0000, 48'h1, 1'b1, 1'b0, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
                "sub_ovf"};
      vt[5] = '{48'h0, 48'h0, 1'b0, 1'b0, 48'h0, 1'b0, 1'b0, 1'b1, "add_zero"};
      vt[6] = '{48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 1'b1, 1'b0, 48'h0, 1'b1, 1'b0, 1'b1,
                "sub_self"};
      vt[7] = '{48'h0000_00FF_FFFF, 48'h0000_0100_0000, 1'b0, 1'b1, 48'h0000_0200_0000, 1'b0,
                1'b0, 1'b0, "add_cin_seg"};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_S", 64'(S), 64'd0);
      chk("rst_Cout", 64'(Cout), 64'd0);
      chk("rst_Ovf", 64'(Ovf), 64'd0);
      chk("rst_Zero", 64'(Zero), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_n_out_valid", 64'(n_out_valid), 64'd0);
      chk("rst_n_in_ready", 64'(n_in_ready), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         run_one(vt[i].a, vt[i].b, vt[i].sb, vt[i].ci, s, co, ov, z, lat);
         chk({vt[i].name, "_latency"}, 64'(lat), 64'd4);
         chk({vt[i].name, "_S"}, 64'(s), 64'(vt[i].s));
         chk({vt[i].name, "_Cout"}, 64'(co), 64'(vt[i].cout));
         chk({vt[i].name, "_Ovf"}, 64'(ov), 64'(vt[i].ovf));
         chk({vt[i].name, "_Zero"}, 64'(z), 64'(vt[i].zero));
      end

      // Single-stage corner
      run_narrow(10'h3FF, 10'h001, 1'b0, 1'b1, ns, co, ov, z, lat);
      chk("narrow_latency", 64'(lat), 64'd1);
      chk("narrow_S", 64'(ns), 64'h001);
      chk("narrow_Cout", 64'(co), 64'd1);
      chk("narrow_Ovf", 64'(ov), 64'd0);
      run_narrow(10'h200, 10'h001, 1'b1, 1'b0, ns, co, ov, z, lat);
      chk("narrow_sub_S", 64'(ns), 64'h1FF);
      chk("narrow_sub_Ovf", 64'(ov), 64'd1);
      chk("narrow_sub_Cout", 64'(co), 64'd1);

      // Backpressure: i+i for i=1..10, consumer stalls in cycles 6-8
      q.delete();
      fired.delete();
      n_stall = 0;
      begin
         int i = 1;
         int c = 1;
         while ((i <= 10 || q.size() > 0) && c < 60) begin
            cycle(i <= 10, 48'(i), 48'(i), 1'b0, 1'b0, !(c >= 6 && c <= 8), acc);
            if (acc) i++;
            c++;
         end
      end
      chk("bp_result_count", 64'(fired.size()), 64'd10);
      chk("bp_stall_cycles", 64'(n_stall), 64'd3);
      for (int j = 0; j < fired.size() && j < 10; j++)
         chk("bp_result_order", fired[j], 64'(2 * (j + 1)));

      // Reset with three operations in flight, plus one offered during reset
      q.delete();
      for (int j = 0; j < 3; j++)
         cycle(1'b1, rand_op(), rand_op(), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), 1'b1, acc);
      rst = 1'b1;
      in_valid = 1'b1;
      in1 = 48'h10;
      in2 = 48'h20;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      q.delete();
      seen = 0;
      repeat (8) begin
         if (out_valid) seen++;
         @(posedge clk);
         #1;
      end
      chk("rst_flush_outputs", 64'(seen), 64'd0);
      run_one(48'd1, 48'd2, 1'b0, 1'b0, s, co, ov, z, lat);
      chk("post_flush_latency", 64'(lat), 64'd4);
      chk("post_flush_S", 64'(s), 64'd3);

      // Randomized traffic with random backpressure
      @(posedge clk);
      #1;
      q.delete();
      repeat (400)
         cycle($urandom_range(0, 9) < 7, rand_op(), rand_op(), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
      repeat (20) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      chk("drain_empty", 64'(q.size()), 64'd0);

      // Randomized single-stage instance
      repeat (40) begin
         logic [NW-1:0] a, b;
         bit            sb, ci;
         a  = NW'($urandom());
         b  = NW'($urandom());
         sb = bit'($urandom_range(0, 1));
         ci = bit'($urandom_range(0, 1));
         e  = model(NW, 64'(a), 64'(b), sb, ci);
         run_narrow(a, b, sb, ci, ns, co, ov, z, lat);
         chk("nrand_latency", 64'(lat), 64'd1);
         chk("nrand_S", 64'(ns), e.s);
         chk("nrand_Cout", 64'(co), 64'(e.cout));
         chk("nrand_Ovf", 64'(ov), 64'(e.ovf));
         chk("nrand_Zero", 64'(z), 64'(e.zero));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
